// File: rtl/packet_disassembler_if.sv
// Valid/ready word stream carrying data plus an end-of-packet marker.
// master drives valid/data/last, slave drives ready.
interface packet_disassembler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/packet_disassembler.sv
// Strips the header word from framed packets and forwards the payload.
// Reports length/framing mismatches and counts error-free packets.
module packet_disassembler #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  packet_disassembler_if.slave            s_in,
  packet_disassembler_if.master           m_out,
  output logic [DATA_WIDTH-LEN_WIDTH-1:0] tagOut,
  output logic                            errShort,
  output logic                            errLong,
  output logic [CNT_WIDTH-1:0]            pktCount
);

  localparam int TAG_WIDTH = DATA_WIDTH - LEN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  state_e                 state_q,     state_d;
  logic [LEN_WIDTH-1:0]   len_q,       len_d;
  logic [LEN_WIDTH-1:0]   cnt_q,       cnt_d;
  logic [TAG_WIDTH-1:0]   tag_q,       tag_d;
  logic                   valid_q,     valid_d;
  logic [DATA_WIDTH-1:0]  data_q,      data_d;
  logic                   last_q,      last_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q,  err_long_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q,   pkt_cnt_d;

  logic                   ready_s;
  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic [LEN_WIDTH-1:0]   hdr_len_s;
  logic [TAG_WIDTH-1:0]   hdr_tag_s;
  logic [LEN_WIDTH-1:0]   cnt_inc_s;
  logic [CNT_WIDTH-1:0]   pkt_inc_s;
  logic                   hdr_len_zero_s;

  // Backpressure only matters while payload is flowing into the output register.
  assign ready_s        = (state_q == ST_PAYLOAD) ? (!valid_q || m_out.ready) : 1'b1;
  assign in_xfer_s      = s_in.valid && ready_s;
  assign out_xfer_s     = valid_q && m_out.ready;
  assign hdr_len_s      = s_in.data[LEN_WIDTH-1:0];
  assign hdr_tag_s      = s_in.data[DATA_WIDTH-1:LEN_WIDTH];
  assign hdr_len_zero_s = (hdr_len_s == {LEN_WIDTH{1'b0}});
  assign cnt_inc_s      = cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign pkt_inc_s      = pkt_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  assign s_in.ready  = ready_s;
  assign m_out.valid = valid_q;
  assign m_out.data  = data_q;
  assign m_out.last  = last_q;
  assign tagOut      = tag_q;
  assign errShort    = err_short_q;
  assign errLong     = err_long_q;
  assign pktCount    = pkt_cnt_q;

  // Next-state, output-register and status computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    data_d      = data_q;
    last_d      = last_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    if (out_xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A held output word stays put here; only the header fields are captured.
        if (in_xfer_s) begin
          tag_d = hdr_tag_s;
          len_d = hdr_len_s;
          cnt_d = {LEN_WIDTH{1'b0}};
          if (!hdr_len_zero_s && !s_in.last) begin
            state_d = ST_PAYLOAD;
          end else if (hdr_len_zero_s && s_in.last) begin
            pkt_cnt_d = pkt_inc_s;
          end else if (hdr_len_zero_s) begin
            err_long_d = 1'b1;
            state_d    = ST_DROP;
          end else begin
            err_short_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (in_xfer_s) begin
          valid_d = 1'b1;
          data_d  = s_in.data;
          cnt_d   = cnt_inc_s;
          if (cnt_inc_s == len_q) begin
            last_d = 1'b1;
            if (s_in.last) begin
              pkt_cnt_d = pkt_inc_s;
              state_d   = ST_IDLE;
            end else begin
              err_long_d = 1'b1;
              state_d    = ST_DROP;
            end
          end else if (s_in.last) begin
            last_d      = 1'b1;
            err_short_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            last_d = 1'b0;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_DROP: begin
        if (in_xfer_s && s_in.last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register update with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= {LEN_WIDTH{1'b0}};
      cnt_q       <= {LEN_WIDTH{1'b0}};
      tag_q       <= {TAG_WIDTH{1'b0}};
      valid_q     <= 1'b0;
      data_q      <= {DATA_WIDTH{1'b0}};
      last_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      pkt_cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_packet_disassembler.sv
// Scoreboard bench for packet_disassembler: directed packets push expected
// payload words, a negedge monitor pops and compares on each output transfer.
module tb_packet_disassembler;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;

  logic          clock;
  logic          reset;
  logic [DW-LW-1:0] tagOut;
  logic          errShort;
  logic          errLong;
  logic [CW-1:0] pktCount;

  packet_disassembler_if #(.DATA_WIDTH(DW)) in_if ();
  packet_disassembler_if #(.DATA_WIDTH(DW)) out_if ();

  packet_disassembler #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_in     (in_if),
    .m_out    (out_if),
    .tagOut   (tagOut),
    .errShort (errShort),
    .errLong  (errLong),
    .pktCount (pktCount)
  );

  int errors = 0;
  int checks = 0;
  int short_seen = 0;
  int long_seen = 0;
  logic [DW:0] sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each output transfer is compared against the oldest expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (errShort) short_seen++;
      if (errLong) long_seen++;
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data 0x%08h last %0b, expected none", out_if.data, out_if.last);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          check("out_data", out_if.data, e[DW-1:0]);
          check("out_last", {31'd0, out_if.last}, {31'd0, e[DW]});
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, input bit exp_out, input logic exp_last);
    bit ok;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.last  = l;
    if (exp_out) sb.push_back({exp_last, d});
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_if.ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1;
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic settle_and_check(input string tname, input int exp_pkt, input int exp_tag,
                                  input int exp_short, input int exp_long);
    repeat (4) @(posedge clock);
    #1;
    check({tname, "_drained"}, sb.size(), 32'd0);
    check({tname, "_pktCount"}, {16'd0, pktCount}, exp_pkt);
    check({tname, "_tagOut"}, {16'd0, tagOut}, exp_tag);
    check({tname, "_errShort_count"}, short_seen, exp_short);
    check({tname, "_errLong_count"}, long_seen, exp_long);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = 32'd0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;
    #12;
    check("rst_validOut", {31'd0, out_if.valid}, 32'd0);
    check("rst_lastOut", {31'd0, out_if.last}, 32'd0);
    check("rst_dataOut", out_if.data, 32'd0);
    check("rst_pktCount", {16'd0, pktCount}, 32'd0);
    check("rst_readyOut", {31'd0, in_if.ready}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: basic three-word packet
    send_word(32'h0001_0003, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_000A, 1'b0, 1'b1, 1'b0);
    send_word(32'h0000_000B, 1'b0, 1'b1, 1'b0);
    send_word(32'h0000_000C, 1'b1, 1'b1, 1'b1);
    settle_and_check("t1", 1, 1, 0, 0);

    // 2: downstream stall while FB is held
    fork
      begin
        send_word(32'h0002_0005, 1'b0, 1'b0, 1'b0);
        send_word(32'h0000_00FA, 1'b0, 1'b1, 1'b0);
        send_word(32'h0000_00FB, 1'b0, 1'b1, 1'b0);
        send_word(32'h0000_00FC, 1'b0, 1'b1, 1'b0);
        send_word(32'h0000_00FD, 1'b0, 1'b1, 1'b0);
        send_word(32'h0000_00FE, 1'b1, 1'b1, 1'b1);
      end
      begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clock);
          #1;
          if (out_if.valid && out_if.data == 32'h0000_00FB) begin
            found = 1'b1;
            break;
          end
        end
        check("t2_saw_FB", {31'd0, found}, 32'd1);
        out_if.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          check("t2_hold_data", out_if.data, 32'h0000_00FB);
          check("t2_hold_valid", {31'd0, out_if.valid}, 32'd1);
          check("t2_readyOut_blocked", {31'd0, in_if.ready}, 32'd0);
          @(posedge clock);
          #1;
        end
        out_if.ready = 1'b1;
      end
    join
    settle_and_check("t2", 2, 2, 0, 0);

    // 3: lastIn before length reached
    send_word(32'h0003_0004, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0011, 1'b0, 1'b1, 1'b0);
    send_word(32'h0000_0022, 1'b1, 1'b1, 1'b1);
    settle_and_check("t3", 2, 3, 1, 0);

    // 4: packet longer than header length, then a clean packet
    send_word(32'h0004_0002, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0033, 1'b0, 1'b1, 1'b0);
    send_word(32'h0000_0044, 1'b0, 1'b1, 1'b1);
    send_word(32'h0000_0055, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0066, 1'b1, 1'b0, 1'b0);
    settle_and_check("t4", 2, 4, 1, 1);
    send_word(32'h0008_0001, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0088, 1'b1, 1'b1, 1'b1);
    settle_and_check("t4b", 3, 8, 1, 1);

    // 5: zero-length packets
    send_word(32'h0005_0000, 1'b1, 1'b0, 1'b0);
    settle_and_check("t5a", 4, 5, 1, 1);
    send_word(32'h0006_0000, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_00D1, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_00D2, 1'b1, 1'b0, 1'b0);
    settle_and_check("t5b", 4, 6, 1, 2);

    // header carrying lastIn with nonzero length
    send_word(32'h0009_0002, 1'b1, 1'b0, 1'b0);
    settle_and_check("t5c", 4, 9, 2, 2);

    // 6: reset mid-packet
    send_word(32'h000A_0005, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0091, 1'b0, 1'b1, 1'b0);
    send_word(32'h0000_0092, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("t6_rst_validOut", {31'd0, out_if.valid}, 32'd0);
    check("t6_rst_dataOut", out_if.data, 32'd0);
    check("t6_rst_tagOut", {16'd0, tagOut}, 32'd0);
    check("t6_rst_pktCount", {16'd0, pktCount}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_word(32'h0007_0001, 1'b0, 1'b0, 1'b0);
    send_word(32'h0000_0077, 1'b1, 1'b1, 1'b1);
    settle_and_check("t6", 1, 7, 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
